// File: rtl/poly_horner_seq.sv
// Sequential Horner-rule polynomial evaluator sharing one multiplier and one adder.
// Optional saturation on MUL/ADD results is enabled by defining POLY_HORNER_SAT_EN.
module poly_horner_seq #(
    parameter int WIDTH  = 16,
    parameter int EXP    = -8,
    parameter int DEGREE = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               coef_we,
    input  logic [$clog2(DEGREE+1)-1:0]        coef_addr,
    input  logic signed [WIDTH-1:0]            coef_data,
    output logic                               coef_err_o,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [WIDTH-1:0]            x_i,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [WIDTH-1:0]            y_o,
    output logic                               ovf_o
);
    localparam int AW = $clog2(DEGREE+1);
    localparam int SH = -EXP;
`ifdef POLY_HORNER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MUL, ADD, DONE} state_t;

    state_t                  state_reg, state_next;
    logic signed [WIDTH-1:0] coef_reg [0:DEGREE];
    logic signed [WIDTH-1:0] x_reg, x_next;
    logic signed [WIDTH-1:0] acc_reg, acc_next;
    logic signed [WIDTH-1:0] prod_reg, prod_next;
    logic [AW-1:0]           k_reg, k_next;
    logic                    ovf_reg, ovf_next;
    logic                    err_reg, err_next;

    logic [DEGREE:0]           coef_hit;
    logic                      coef_wr;
    logic signed [WIDTH-1:0]   coef_k;
    logic signed [2*WIDTH-1:0] mul_full;
    logic signed [2*WIDTH-1:0] mul_shift;
    logic                      mul_ovf;
    logic signed [WIDTH-1:0]   mul_res;
    logic signed [WIDTH:0]     add_sum;
    logic                      add_ovf;
    logic signed [WIDTH-1:0]   add_res;

    // Out-of-range addresses hit no slot, so they neither write nor flag an error.
    genvar gi;
    generate
        for (gi = 0; gi <= DEGREE; gi++) begin : g_hit
            assign coef_hit[gi] = coef_we && (coef_addr == AW'(gi));
        end
    endgenerate

    assign coef_wr = (state_reg == IDLE) && (|coef_hit);
    assign coef_k  = coef_reg[k_reg];

    // Floor-scaled product; in range only when the bits above the result sign all agree.
    assign mul_full  = acc_reg * x_reg;
    assign mul_shift = mul_full >>> SH;
    assign mul_ovf   = !((&mul_shift[2*WIDTH-1:WIDTH-1]) || !(|mul_shift[2*WIDTH-1:WIDTH-1]));
    assign mul_res   = (SAT && mul_ovf) ? (mul_shift[2*WIDTH-1] ? MIN_V : MAX_V)
                                        : mul_shift[WIDTH-1:0];

    assign add_sum = {prod_reg[WIDTH-1], prod_reg} + {coef_k[WIDTH-1], coef_k};
    assign add_ovf = add_sum[WIDTH] ^ add_sum[WIDTH-1];
    assign add_res = (SAT && add_ovf) ? (add_sum[WIDTH] ? MIN_V : MAX_V)
                                      : add_sum[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        acc_next   = acc_reg;
        prod_next  = prod_reg;
        k_next     = k_reg;
        ovf_next   = ovf_reg;
        err_next   = err_reg;
        if (coef_we && (|coef_hit) && (state_reg != IDLE)) begin
            err_next = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    x_next     = x_i;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                acc_next   = coef_reg[DEGREE];
                k_next     = AW'(DEGREE-1);
                ovf_next   = 1'b0;
                state_next = MUL;
            end
            MUL: begin
                prod_next  = mul_res;
                ovf_next   = ovf_reg | (SAT & mul_ovf);
                state_next = ADD;
            end
            ADD: begin
                acc_next = add_res;
                ovf_next = ovf_reg | (SAT & add_ovf);
                if (k_reg == '0) begin
                    state_next = DONE;
                end else begin
                    k_next     = k_reg - 1'b1;
                    state_next = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            acc_reg   <= '0;
            prod_reg  <= '0;
            k_reg     <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
            for (int i = 0; i <= DEGREE; i++) begin
                coef_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            acc_reg   <= acc_next;
            prod_reg  <= prod_next;
            k_reg     <= k_next;
            ovf_reg   <= ovf_next;
            err_reg   <= err_next;
            for (int i = 0; i <= DEGREE; i++) begin
                if (coef_wr && coef_hit[i]) begin
                    coef_reg[i] <= coef_data;
                end
            end
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign y_o        = acc_reg;
    assign ovf_o      = SAT ? ovf_reg : 1'b0;
    assign coef_err_o = err_reg;

endmodule
